// File: rtl/enlp_sequencer_if.sv
// Bundle of command, loop-feedback, loop-control and status signals for enlp_sequencer.
`timescale 1ns/1ps

interface enlp_sequencer_if;
  logic       SEQ_START;
  logic       SEQ_STOP;
  logic       FAULT_CLR;
  logic       PWRENLP_STATE;
  logic       MTNENLP_STATE;
  logic       BMENLP_STATE;
  logic       KVBMENLP_STATE;
  logic       PWRENLP_CNTL;
  logic       MTNENLP_CNTL;
  logic       BMENLP_CNTL;
  logic       KVBMENLP_CNTL;
  logic       SEQ_BUSY;
  logic       SEQ_DONE;
  logic       SEQ_FAULT;
  logic [1:0] FAULT_CODE;
  logic [2:0] FAULT_STAGE;
  logic [2:0] SEQ_STATE;

  modport slave (
    input  SEQ_START, SEQ_STOP, FAULT_CLR,
    input  PWRENLP_STATE, MTNENLP_STATE, BMENLP_STATE, KVBMENLP_STATE,
    output PWRENLP_CNTL, MTNENLP_CNTL, BMENLP_CNTL, KVBMENLP_CNTL,
    output SEQ_BUSY, SEQ_DONE, SEQ_FAULT, FAULT_CODE, FAULT_STAGE, SEQ_STATE
  );

  modport master (
    output SEQ_START, SEQ_STOP, FAULT_CLR,
    output PWRENLP_STATE, MTNENLP_STATE, BMENLP_STATE, KVBMENLP_STATE,
    input  PWRENLP_CNTL, MTNENLP_CNTL, BMENLP_CNTL, KVBMENLP_CNTL,
    input  SEQ_BUSY, SEQ_DONE, SEQ_FAULT, FAULT_CODE, FAULT_STAGE, SEQ_STATE
  );
endinterface

// File: rtl/enlp_sequencer.sv
// Enable-loop sequencer: brings up power, motion, (KVBM) and beam loops in order with timeout
// and loss monitoring. Define ENLP_SEQ_KVBM_EN to insert the KVBM stage.
`timescale 1ns/1ps

module enlp_sequencer #(
  parameter int unsigned TIMEOUT_W   = 16,
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input logic             OPB_CLK,
  input logic             OPB_RST_N,
  enlp_sequencer_if.slave bus
);

`ifdef ENLP_SEQ_KVBM_EN
  localparam bit KvbmEn = 1'b1;
`else
  localparam bit KvbmEn = 1'b0;
`endif

  localparam logic [TIMEOUT_W-1:0] CntLast = TIMEOUT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StPwrWait  = 3'd1,
    StMtnWait  = 3'd2,
    StKvbmWait = 3'd3,
    StBmWait   = 3'd4,
    StRun      = 3'd5,
    StFault    = 3'd6,
    StUnused   = 3'd7
  } state_e;

  // Loop bit order everywhere: 0 pwr, 1 mtn, 2 kvbm, 3 bm
  logic [3:0]           fb_raw, fb_meta_q, fb_sync_q;
  state_e               state_q, state_d, adv_state;
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
  logic [1:0]           code_q, code_d;
  logic [2:0]           stage_q, stage_d;
  logic [3:0]           cntl_q, cntl_d, monitor;
  logic                 busy_q, busy_d, done_q, done_d, fault_q, fault_d;
  logic                 waiting, stage_fb, illegal, loss;

  assign fb_raw = {bus.BMENLP_STATE, KvbmEn & bus.KVBMENLP_STATE,
                   bus.MTNENLP_STATE, bus.PWRENLP_STATE};

  // Per-state stage decode: which feedback advances, which established loops are monitored
  always_comb begin
    waiting   = 1'b0;
    stage_fb  = 1'b0;
    monitor   = 4'b0000;
    adv_state = state_q;
    illegal   = 1'b0;
    case (state_q)
      StPwrWait: begin
        waiting   = 1'b1;
        stage_fb  = fb_sync_q[0];
        adv_state = StMtnWait;
      end
      StMtnWait: begin
        waiting   = 1'b1;
        stage_fb  = fb_sync_q[1];
        monitor   = 4'b0001;
        adv_state = KvbmEn ? StKvbmWait : StBmWait;
      end
      StKvbmWait: begin
        waiting   = KvbmEn;
        stage_fb  = fb_sync_q[2];
        monitor   = 4'b0011;
        adv_state = StBmWait;
        illegal   = !KvbmEn;
      end
      StBmWait: begin
        waiting   = 1'b1;
        stage_fb  = fb_sync_q[3];
        monitor   = {1'b0, KvbmEn, 2'b11};
        adv_state = StRun;
      end
      StRun:    monitor = {1'b1, KvbmEn, 2'b11};
      StUnused: illegal = 1'b1;
      default:  ;
    endcase
  end

  assign loss = |(monitor & ~fb_sync_q);

  // Priority among active states: loss, stop, feedback advance, timeout
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    stage_d = stage_q;
    if (state_q == StIdle) begin
      if (bus.SEQ_START && !bus.SEQ_STOP) state_d = StPwrWait;
    end else if (state_q == StFault) begin
      if (bus.FAULT_CLR) begin
        state_d = StIdle;
        code_d  = 2'd0;
        stage_d = 3'd0;
      end
    end else if (illegal) begin
      state_d = StIdle;
    end else if (loss) begin
      state_d = StFault;
      code_d  = 2'd2;
      stage_d = state_q;
    end else if (bus.SEQ_STOP) begin
      state_d = StIdle;
    end else if (waiting && stage_fb) begin
      state_d = adv_state;
    end else if (waiting && (cnt_q == CntLast)) begin
      state_d = StFault;
      code_d  = 2'd1;
      stage_d = state_q;
    end
  end

  assign cnt_d = (waiting && (state_d == state_q)) ? cnt_q + 1'b1 : '0;

  // Outputs are decoded from the next state so every output is a flop
  always_comb begin
    cntl_d  = 4'b0000;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    fault_d = 1'b0;
    case (state_d)
      StPwrWait: begin
        cntl_d = 4'b0001;
        busy_d = 1'b1;
      end
      StMtnWait: begin
        cntl_d = 4'b0011;
        busy_d = 1'b1;
      end
      StKvbmWait: begin
        cntl_d = {1'b0, KvbmEn, 2'b11};
        busy_d = KvbmEn;
      end
      StBmWait: begin
        cntl_d = {1'b1, KvbmEn, 2'b11};
        busy_d = 1'b1;
      end
      StRun: begin
        cntl_d = {1'b1, KvbmEn, 2'b11};
        done_d = 1'b1;
      end
      StFault: fault_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge OPB_CLK) begin
    if (!OPB_RST_N) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      fb_meta_q <= 4'b0000;
      fb_sync_q <= 4'b0000;
      code_q    <= 2'd0;
      stage_q   <= 3'd0;
      cntl_q    <= 4'b0000;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      fb_meta_q <= fb_raw;
      fb_sync_q <= fb_meta_q;
      code_q    <= code_d;
      stage_q   <= stage_d;
      cntl_q    <= cntl_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      fault_q   <= fault_d;
    end
  end

  assign bus.PWRENLP_CNTL  = cntl_q[0];
  assign bus.MTNENLP_CNTL  = cntl_q[1];
  assign bus.KVBMENLP_CNTL = cntl_q[2];
  assign bus.BMENLP_CNTL   = cntl_q[3];
  assign bus.SEQ_BUSY      = busy_q;
  assign bus.SEQ_DONE      = done_q;
  assign bus.SEQ_FAULT     = fault_q;
  assign bus.FAULT_CODE    = code_q;
  assign bus.FAULT_STAGE   = stage_q;
  assign bus.SEQ_STATE     = state_q;

endmodule

// File: tb/tb_enlp_sequencer.sv
// Bench for enlp_sequencer: stage-list reference model compared every cycle, plus directed
// literal checks. Honours ENLP_SEQ_KVBM_EN like the design.
`timescale 1ns/1ps

module tb_enlp_sequencer;
  localparam int TCyc = 16;
`ifdef ENLP_SEQ_KVBM_EN
  localparam int NSt = 4;
`else
  localparam int NSt = 3;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  enlp_sequencer_if bus ();

  enlp_sequencer #(
    .TIMEOUT_W  (16),
    .TIMEOUT_CYC(TCyc)
  ) dut (
    .OPB_CLK  (clk),
    .OPB_RST_N(rst_n),
    .bus      (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Stage list: SEQ_STATE code and feedback bit (0 pwr, 1 mtn, 2 kvbm, 3 bm) of each stage
  int st_code[4];
  int st_fb[4];
  initial begin
`ifdef ENLP_SEQ_KVBM_EN
    st_code = '{1, 2, 3, 4};
    st_fb   = '{0, 1, 2, 3};
`else
    st_code = '{1, 2, 4, 0};
    st_fb   = '{0, 1, 3, 0};
`endif
  end

  // Model: m_pos 0 = idle, 1..NSt = waiting in stage m_pos-1, NSt+1 = run
  int         m_pos = 0;
  bit         m_fault = 1'b0;
  int         m_cnt = 0;
  int         m_code = 0;
  int         m_stage = 0;
  logic [3:0] m_s1 = 4'b0;
  logic [3:0] m_s2 = 4'b0;

  function automatic int cur_code();
    if (m_fault) return 6;
    if (m_pos == 0) return 0;
    if (m_pos <= NSt) return st_code[m_pos-1];
    return 5;
  endfunction

  function automatic logic [14:0] exp_vec();
    logic [3:0] c;
    c = 4'b0;
    for (int i = 0; i < NSt; i++) if (!m_fault && m_pos > i) c[st_fb[i]] = 1'b1;
    return {c, !m_fault && m_pos >= 1 && m_pos <= NSt, !m_fault && m_pos == NSt + 1, m_fault,
            2'(m_code), 3'(m_stage), 3'(cur_code())};
  endfunction

  function automatic logic [14:0] dut_vec();
    return {bus.BMENLP_CNTL, bus.KVBMENLP_CNTL, bus.MTNENLP_CNTL, bus.PWRENLP_CNTL,
            bus.SEQ_BUSY, bus.SEQ_DONE, bus.SEQ_FAULT, bus.FAULT_CODE, bus.FAULT_STAGE,
            bus.SEQ_STATE};
  endfunction

  always @(posedge clk) begin : model_p
    logic [3:0] fb_in;
    bit lost;
    fb_in = {bus.BMENLP_STATE, bus.KVBMENLP_STATE, bus.MTNENLP_STATE, bus.PWRENLP_STATE};
    lost = 1'b0;
    if (!rst_n) begin
      m_pos = 0; m_fault = 1'b0; m_cnt = 0; m_code = 0; m_stage = 0;
      m_s1 = 4'b0; m_s2 = 4'b0;
    end else begin
      if (m_fault) begin
        if (bus.FAULT_CLR) begin
          m_fault = 1'b0; m_code = 0; m_stage = 0;
        end
      end else if (m_pos == 0) begin
        if (bus.SEQ_START && !bus.SEQ_STOP) begin
          m_pos = 1; m_cnt = 0;
        end
      end else begin
        for (int i = 0; i < m_pos - 1 && i < NSt; i++) if (!m_s2[st_fb[i]]) lost = 1'b1;
        if (lost) begin
          m_stage = cur_code(); m_code = 2; m_fault = 1'b1; m_pos = 0;
        end else if (bus.SEQ_STOP) begin
          m_pos = 0;
        end else if (m_pos <= NSt) begin
          if (m_s2[st_fb[m_pos-1]]) begin
            m_pos++; m_cnt = 0;
          end else if (m_cnt == TCyc - 1) begin
            m_stage = cur_code(); m_code = 1; m_fault = 1'b1; m_pos = 0;
          end else begin
            m_cnt++;
          end
        end
      end
      m_s2 = m_s1;
      m_s1 = fb_in;
    end
  end

  always @(negedge clk) if (chk_en) check("outputs_vs_model", 32'(dut_vec()), 32'(exp_vec()));

  logic [3:0] fb = 4'b0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fb(input logic [3:0] v);
    fb = v;
    bus.PWRENLP_STATE  = v[0];
    bus.MTNENLP_STATE  = v[1];
    bus.KVBMENLP_STATE = v[2];
    bus.BMENLP_STATE   = v[3];
  endtask

  task automatic pulse(input logic s, input logic p, input logic c);
    bus.SEQ_START = s;
    bus.SEQ_STOP  = p;
    bus.FAULT_CLR = c;
    tick();
    bus.SEQ_START = 1'b0;
    bus.SEQ_STOP  = 1'b0;
    bus.FAULT_CLR = 1'b0;
  endtask

  task automatic wait_state(input int code, input int budget, input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      if (int'(bus.SEQ_STATE) == code) seen = 1'b1;
      else tick();
    end
    if (!seen) check(name, 32'(bus.SEQ_STATE), 32'(code));
  endtask

  task automatic clear_all();
    set_fb(4'b0);
    pulse(1'b0, 1'b1, 1'b0);
    pulse(1'b0, 1'b0, 1'b1);
    tick();
    tick();
  endtask

  initial begin
    bus.SEQ_START = 1'b0;
    bus.SEQ_STOP  = 1'b0;
    bus.FAULT_CLR = 1'b0;
    set_fb(4'b0);
    tick();
    tick();
    check("reset_outputs", 32'(dut_vec()), 32'h0);
    chk_en = 1'b1;
    rst_n = 1'b1;
    tick();

    // Happy path, each feedback raised 3 cycles after its CNTL
    pulse(1'b1, 1'b0, 1'b0);
    check("start_state", 32'(bus.SEQ_STATE), 32'd1);
    check("start_busy", 32'(bus.SEQ_BUSY), 32'd1);
    check("start_pwr_cntl", 32'(bus.PWRENLP_CNTL), 32'd1);
    for (int s = 0; s < NSt; s++) begin
      repeat (3) tick();
      set_fb(fb | (4'b1 << st_fb[s]));
      repeat (2) tick();
      check("fb_latency_not_early", 32'(bus.SEQ_STATE), 32'(st_code[s]));
      tick();
      check("fb_advance", 32'(bus.SEQ_STATE), (s == NSt - 1) ? 32'd5 : 32'(st_code[s+1]));
    end
    check("run_done", 32'(bus.SEQ_DONE), 32'd1);
    check("run_fault", 32'(bus.SEQ_FAULT), 32'd0);
    check("run_cntl", 32'({bus.BMENLP_CNTL, bus.KVBMENLP_CNTL, bus.MTNENLP_CNTL,
                           bus.PWRENLP_CNTL}), (NSt == 4) ? 32'hF : 32'hB);

    // Loss in RUN
    set_fb(fb & 4'b1101);
    repeat (2) tick();
    check("loss_not_early", 32'(bus.SEQ_STATE), 32'd5);
    tick();
    check("loss_state", 32'(bus.SEQ_STATE), 32'd6);
    check("loss_code", 32'(bus.FAULT_CODE), 32'd2);
    check("loss_stage", 32'(bus.FAULT_STAGE), 32'd5);
    check("loss_cntl_low", 32'({bus.BMENLP_CNTL, bus.KVBMENLP_CNTL, bus.MTNENLP_CNTL,
                                bus.PWRENLP_CNTL}), 32'h0);
    pulse(1'b1, 1'b0, 1'b0);
    check("fault_ignores_start", 32'(bus.SEQ_STATE), 32'd6);
    pulse(1'b0, 1'b1, 1'b0);
    check("fault_ignores_stop", 32'(bus.FAULT_CODE), 32'd2);
    set_fb(4'b0);
    pulse(1'b0, 1'b0, 1'b1);
    check("clr_state", 32'(bus.SEQ_STATE), 32'd0);
    check("clr_code", 32'(bus.FAULT_CODE), 32'd0);
    check("clr_stage", 32'(bus.FAULT_STAGE), 32'd0);
    tick();
    tick();

    // Timeout with PWR feedback held low
    pulse(1'b1, 1'b0, 1'b0);
    repeat (15) tick();
    check("timeout_not_early", 32'(bus.SEQ_STATE), 32'd1);
    tick();
    check("timeout_state", 32'(bus.SEQ_STATE), 32'd6);
    check("timeout_code", 32'(bus.FAULT_CODE), 32'd1);
    check("timeout_stage", 32'(bus.FAULT_STAGE), 32'd1);
    check("timeout_cntl_low", 32'(bus.PWRENLP_CNTL), 32'd0);
    pulse(1'b0, 1'b0, 1'b1);
    check("timeout_clr_code", 32'(bus.FAULT_CODE), 32'd0);
    tick();

    // Boundary: feedback visible at counter 15 advances
    pulse(1'b1, 1'b0, 1'b0);
    repeat (13) tick();
    set_fb(4'b0001);
    repeat (3) tick();
    check("boundary_advance", 32'(bus.SEQ_STATE), 32'd2);
    check("boundary_no_fault", 32'(bus.SEQ_FAULT), 32'd0);
    clear_all();

    // Boundary: one cycle later times out
    pulse(1'b1, 1'b0, 1'b0);
    repeat (14) tick();
    set_fb(4'b0001);
    repeat (2) tick();
    check("boundary_late_state", 32'(bus.SEQ_STATE), 32'd6);
    check("boundary_late_code", 32'(bus.FAULT_CODE), 32'd1);
    clear_all();

    // Priority: STOP with START in IDLE
    pulse(1'b1, 1'b1, 1'b0);
    check("stop_start_idle", 32'(bus.SEQ_STATE), 32'd0);

    // Minimum START-to-RUN latency with all feedback high
    set_fb(4'b1111);
    tick();
    tick();
    pulse(1'b1, 1'b0, 1'b0);
    repeat (NSt - 1) tick();
    check("min_latency_not_early", 32'(bus.SEQ_STATE), 32'd4);
    tick();
    check("min_latency_run", 32'(bus.SEQ_STATE), 32'd5);
    clear_all();

    // STOP in BM_WAIT
    set_fb(4'b0111);
    tick();
    tick();
    pulse(1'b1, 1'b0, 1'b0);
    wait_state(4, 10, "reach_bm_wait");
    pulse(1'b0, 1'b1, 1'b0);
    check("stop_bm_state", 32'(bus.SEQ_STATE), 32'd0);
    check("stop_bm_cntl", 32'({bus.BMENLP_CNTL, bus.KVBMENLP_CNTL, bus.MTNENLP_CNTL,
                               bus.PWRENLP_CNTL}), 32'h0);
    clear_all();

    // Reset in MTN_WAIT
    set_fb(4'b0001);
    tick();
    tick();
    pulse(1'b1, 1'b0, 1'b0);
    wait_state(2, 10, "reach_mtn_wait");
    rst_n = 1'b0;
    tick();
    check("midreset_outputs", 32'(dut_vec()), 32'h0);
    rst_n = 1'b1;
    set_fb(4'b0);
    tick();
    tick();

`ifdef ENLP_SEQ_KVBM_EN
    // KVBM loss in BM_WAIT
    set_fb(4'b0111);
    tick();
    tick();
    pulse(1'b1, 1'b0, 1'b0);
    wait_state(4, 10, "kvbm_reach_bm_wait");
    check("kvbm_cntl", 32'(bus.KVBMENLP_CNTL), 32'd1);
    set_fb(4'b0011);
    repeat (3) tick();
    check("kvbm_loss_code", 32'(bus.FAULT_CODE), 32'd2);
    check("kvbm_loss_stage", 32'(bus.FAULT_STAGE), 32'd4);
    clear_all();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", n_checks,
             n_errors);
    $fatal(1);
  end

endmodule
